// File: rtl/rcu.sv
// rcu -- USB receiver control unit.
// Moore FSM that sequences packet reception: waits for line activity,
// validates the sync byte, strobes each received data byte into the FIFO,
// and tracks end-of-packet and error recovery.
// Optional feature: define RCU_BYTE_CNT_EN to add a saturating 7-bit
// byte_count output that counts bytes stored in the current packet.
module rcu (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       d_edge,
   input  logic       eop,
   input  logic       shift_enable,
   input  logic       byte_received,
   input  logic [7:0] rcv_data,
   output logic       rcving,
   output logic       w_enable,
   output logic       r_error
`ifdef RCU_BYTE_CNT_EN
   ,
   output logic [6:0] byte_count
`endif
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      SYNC_RCV = 4'd1,
      CHK_SYNC = 4'd2,
      RCV_BYTE = 4'd3,
      STORE    = 4'd4,
      EOP_WAIT = 4'd5,
      ERR      = 4'd6,
      ERR_EOP  = 4'd7,
      EIDLE    = 4'd8
   } state_t;

   state_t state_r;
   state_t next_state_s;
   logic   partial_r;
   logic   eop_se_s;
   logic   rcving_s;
   logic   w_enable_s;
   logic   r_error_s;

   // An EOP only counts when it is seen on a bit-sample strobe.
   assign eop_se_s = eop & shift_enable;

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; byte_received is tested before EOP so a byte
   // completing on the EOP sample is still stored.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (d_edge) next_state_s = SYNC_RCV;
            else        next_state_s = IDLE;
         end
         SYNC_RCV: begin
            if (byte_received) next_state_s = CHK_SYNC;
            else if (eop_se_s) next_state_s = ERR;
            else               next_state_s = SYNC_RCV;
         end
         CHK_SYNC: begin
            if (rcv_data == 8'h80) next_state_s = RCV_BYTE;
            else                   next_state_s = ERR;
         end
         RCV_BYTE: begin
            if (byte_received)              next_state_s = STORE;
            else if (eop_se_s && !partial_r) next_state_s = EOP_WAIT;
            else if (eop_se_s)              next_state_s = ERR;
            else                            next_state_s = RCV_BYTE;
         end
         STORE: begin
            next_state_s = RCV_BYTE;
         end
         EOP_WAIT: begin
            if (d_edge) next_state_s = IDLE;
            else        next_state_s = EOP_WAIT;
         end
         ERR: begin
            if (eop_se_s) next_state_s = ERR_EOP;
            else          next_state_s = ERR;
         end
         ERR_EOP: begin
            if (d_edge) next_state_s = EIDLE;
            else        next_state_s = ERR_EOP;
         end
         EIDLE: begin
            if (d_edge) next_state_s = SYNC_RCV;
            else        next_state_s = EIDLE;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Output decode of the state being entered, so the registered outputs
   // line up exactly with state_r.
   always_comb begin
      rcving_s   = 1'b0;
      w_enable_s = 1'b0;
      r_error_s  = 1'b0;
      case (next_state_s)
         IDLE: begin
            rcving_s = 1'b0;
         end
         SYNC_RCV, CHK_SYNC, RCV_BYTE, EOP_WAIT: begin
            rcving_s = 1'b1;
         end
         STORE: begin
            rcving_s   = 1'b1;
            w_enable_s = 1'b1;
         end
         ERR, ERR_EOP: begin
            rcving_s  = 1'b1;
            r_error_s = 1'b1;
         end
         EIDLE: begin
            r_error_s = 1'b1;
         end
         default: begin
            rcving_s = 1'b0;
         end
      endcase
   end

   // Output registers; reset clears them without waiting for a clock.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rcving   <= 1'b0;
         w_enable <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         rcving   <= rcving_s;
         w_enable <= w_enable_s;
         r_error  <= r_error_s;
      end
   end

   // Partial-bit flag: marks a data byte that has started shifting, so an
   // EOP mid-byte is an error while an EOP on a byte boundary is not.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         partial_r <= 1'b0;
      end else if ((next_state_s == RCV_BYTE) && (state_r != RCV_BYTE)) begin
         partial_r <= 1'b0;
      end else if ((state_r == RCV_BYTE) && shift_enable) begin
         partial_r <= 1'b1;
      end else begin
         partial_r <= partial_r;
      end
   end

`ifdef RCU_BYTE_CNT_EN
   // Per-packet stored-byte counter, cleared when a packet starts and held
   // after it ends so it can be read back while idle.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         byte_count <= 7'd0;
      end else if ((next_state_s == SYNC_RCV) && (state_r != SYNC_RCV)) begin
         byte_count <= 7'd0;
      end else if ((state_r == STORE) && (byte_count != 7'd127)) begin
         byte_count <= byte_count + 7'd1;
      end else begin
         byte_count <= byte_count;
      end
   end
`endif

endmodule
